// File: rtl/pipe_collision_scorer_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_collision_scorer_if
// Description : Bundle of the game-control, bird/pipe geometry and
//               score/state signals exchanged with pipe_collision_scorer.
//               slave  - seen by the scorer (geometry in, state/score out)
//               master - seen by the driver  (geometry out, state/score in)
//   Start, Ack, Frame_Tick          : game control and per-frame strobe
//   Bird_X, Bird_Y                  : signed bird top-left corner
//   Pipe_Valid, Pipe_X_Left/Right,
//   Gap_Top, Gap_Bottom             : packed per-pipe geometry
//   Q_Initial, Q_Check, Q_Lose      : one-hot game state
//   Score, High_Score, Hit_Index,
//   Pass_Pulse                      : scoring results
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_collision_scorer_if #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 10,
    parameter int SCORE_W   = 8
);
    logic                           Start;
    logic                           Ack;
    logic                           Frame_Tick;
    logic [COORD_W-1:0]             Bird_X;
    logic [COORD_W-1:0]             Bird_Y;
    logic [NUM_PIPES-1:0]           Pipe_Valid;
    logic [NUM_PIPES*COORD_W-1:0]   Pipe_X_Left;
    logic [NUM_PIPES*COORD_W-1:0]   Pipe_X_Right;
    logic [NUM_PIPES*COORD_W-1:0]   Gap_Top;
    logic [NUM_PIPES*COORD_W-1:0]   Gap_Bottom;
    logic                           Q_Initial;
    logic                           Q_Check;
    logic                           Q_Lose;
    logic [SCORE_W-1:0]             Score;
    logic [SCORE_W-1:0]             High_Score;
    logic [3:0]                     Hit_Index;
    logic                           Pass_Pulse;

    modport slave (
        input  Start, Ack, Frame_Tick, Bird_X, Bird_Y, Pipe_Valid,
               Pipe_X_Left, Pipe_X_Right, Gap_Top, Gap_Bottom,
        output Q_Initial, Q_Check, Q_Lose, Score, High_Score, Hit_Index,
               Pass_Pulse
    );

    modport master (
        output Start, Ack, Frame_Tick, Bird_X, Bird_Y, Pipe_Valid,
               Pipe_X_Left, Pipe_X_Right, Gap_Top, Gap_Bottom,
        input  Q_Initial, Q_Check, Q_Lose, Score, High_Score, Hit_Index,
               Pass_Pulse
    );
endinterface
`default_nettype wire

// File: rtl/pipe_collision_scorer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_collision_scorer
// Description : Flappy-VGA game state and collision block. Once per frame
//               (Frame_Tick) the bird hitbox is checked against NUM_PIPES
//               pipes plus floor/ceiling; passed pipes add to a saturating
//               score. Drives the one-hot Initial/Check/Lose state.
// Ports       : Clk   - system clock
//               reset - asynchronous active-high reset
//               bus   - pipe_collision_scorer_if.slave (controls, geometry,
//                       state flags, Score, High_Score, Hit_Index,
//                       Pass_Pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_collision_scorer #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 10,
    parameter int BIRD_W    = 16,
    parameter int BIRD_H    = 12,
    parameter int SCORE_W   = 8,
    parameter int FLOOR_Y   = 464,
    parameter int CEIL_Y    = 0
) (
    input  wire logic               Clk,
    input  wire logic               reset,
    pipe_collision_scorer_if.slave  bus
);
    // Two guard bits keep bird edges that go off-screen (negative, or past
    // the coordinate range after adding the hitbox size) comparable.
    localparam int c_CMP_W = COORD_W + 2;
    localparam int c_CNT_W = 4;
    localparam int c_SUM_W = SCORE_W + c_CNT_W;

    localparam logic signed [c_CMP_W-1:0] c_BIRD_W  = c_CMP_W'(BIRD_W);
    localparam logic signed [c_CMP_W-1:0] c_BIRD_H  = c_CMP_W'(BIRD_H);
    localparam logic signed [c_CMP_W-1:0] c_FLOOR_Y = c_CMP_W'(FLOOR_Y);
    localparam logic signed [c_CMP_W-1:0] c_CEIL_Y  = c_CMP_W'(CEIL_Y);
    localparam logic [SCORE_W-1:0]        c_SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_INITIAL = 3'b001,
        S_CHECK   = 3'b010,
        S_LOSE    = 3'b100
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [SCORE_W-1:0]         r_score;
    logic [SCORE_W-1:0]         r_high;
    logic [3:0]                 r_hit_idx;
    logic                       r_pass_pulse;
    logic [NUM_PIPES-1:0]       r_passed;

    logic signed [c_CMP_W-1:0]  w_bx0, w_bx1, w_by0, w_by1;
    logic [NUM_PIPES-1:0]       w_hit;
    logic [NUM_PIPES-1:0]       w_pass;
    logic [NUM_PIPES-1:0]       w_clear;
    logic                       w_bound_hit;
    logic                       w_hit_any;
    logic [3:0]                 w_hit_idx;
    logic [c_CNT_W-1:0]         w_pass_cnt;
    logic [c_SUM_W-1:0]         w_score_sum;
    logic [SCORE_W-1:0]         w_score_sat;
    logic                       w_start_evt;
    logic                       w_eval;
    logic                       w_lose_evt;
    logic                       w_score_evt;

    // ------------------------------------------------------------------
    // Bird hitbox edges (sign-extended)
    // ------------------------------------------------------------------
    assign w_bx0 = {{2{bus.Bird_X[COORD_W-1]}}, bus.Bird_X};
    assign w_by0 = {{2{bus.Bird_Y[COORD_W-1]}}, bus.Bird_Y};
    assign w_bx1 = w_bx0 + c_BIRD_W;
    assign w_by1 = w_by0 + c_BIRD_H;

    // ------------------------------------------------------------------
    // Per-pipe collision, pass and respawn detection
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
        logic signed [c_CMP_W-1:0] w_left, w_right, w_gap_top, w_gap_bot;

        assign w_left    = {2'b00, bus.Pipe_X_Left [gi*COORD_W +: COORD_W]};
        assign w_right   = {2'b00, bus.Pipe_X_Right[gi*COORD_W +: COORD_W]};
        assign w_gap_top = {2'b00, bus.Gap_Top     [gi*COORD_W +: COORD_W]};
        assign w_gap_bot = {2'b00, bus.Gap_Bottom  [gi*COORD_W +: COORD_W]};

        // Strict compares: touching an edge is not a collision.
        assign w_hit[gi]   = bus.Pipe_Valid[gi] &&
                             (w_bx1 > w_left) && (w_bx0 < w_right) &&
                             ((w_by0 < w_gap_top) || (w_by1 > w_gap_bot));
        assign w_pass[gi]  = bus.Pipe_Valid[gi] && !r_passed[gi] &&
                             (w_bx0 >= w_right);
        // A pipe back ahead of the bird (or disabled) is a new pipe.
        assign w_clear[gi] = !bus.Pipe_Valid[gi] || (w_left > w_bx1);
    end

    assign w_bound_hit = (w_by1 > c_FLOOR_Y) || (w_by0 < c_CEIL_Y);
    assign w_hit_any   = (|w_hit) || w_bound_hit;

    // Lowest hit pipe wins; 15 flags a floor/ceiling loss.
    always_comb begin
        w_hit_idx  = 4'd15;
        w_pass_cnt = '0;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_idx = 4'(i);
            end
        end
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_pass_cnt = w_pass_cnt + {{(c_CNT_W-1){1'b0}}, w_pass[i]};
        end
    end

    assign w_score_sum = c_SUM_W'(r_score) + c_SUM_W'(w_pass_cnt);
    assign w_score_sat = (w_score_sum > c_SUM_W'(c_SCORE_MAX)) ?
                         c_SCORE_MAX : w_score_sum[SCORE_W-1:0];

    assign w_start_evt = (r_state == S_INITIAL) && bus.Start;
    assign w_eval      = (r_state == S_CHECK) && bus.Frame_Tick;
    // A collision suppresses any scoring on the same frame.
    assign w_lose_evt  = w_eval && w_hit_any;
    assign w_score_evt = w_eval && !w_hit_any;

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INITIAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_INITIAL;
        case (r_state)
            S_INITIAL: w_state_next = bus.Start  ? S_CHECK   : S_INITIAL;
            S_CHECK:   w_state_next = w_lose_evt ? S_LOSE    : S_CHECK;
            S_LOSE:    w_state_next = bus.Ack    ? S_INITIAL : S_LOSE;
            default:   w_state_next = S_INITIAL;
        endcase
    end

    // ------------------------------------------------------------------
    // Score, high score, hit source and passed flags
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_score      <= '0;
            r_high       <= '0;
            r_hit_idx    <= 4'd0;
            r_pass_pulse <= 1'b0;
            r_passed     <= '0;
        end else begin
            r_pass_pulse <= w_score_evt && (w_pass_cnt != '0);

            if (w_start_evt) begin
                r_score <= '0;
            end else if (w_score_evt) begin
                r_score <= w_score_sat;
            end

            if (w_lose_evt) begin
                r_hit_idx <= w_hit_idx;
                if (r_score > r_high) begin
                    r_high <= r_score;
                end
            end

            // Clear has priority over set.
            if (w_start_evt) begin
                r_passed <= '0;
            end else begin
                r_passed <= (r_passed | (w_pass & {NUM_PIPES{w_score_evt}}))
                            & ~w_clear;
            end
        end
    end

    assign bus.Q_Initial  = r_state[0];
    assign bus.Q_Check    = r_state[1];
    assign bus.Q_Lose     = r_state[2];
    assign bus.Score      = r_score;
    assign bus.High_Score = r_high;
    assign bus.Hit_Index  = r_hit_idx;
    assign bus.Pass_Pulse = r_pass_pulse;

endmodule
`default_nettype wire

// File: doc/pipe_collision_scorer.md
Name: pipe_collision_scorer

Overview:
- Parametrised game-state and collision block for Flappy-VGA.
- Checks the bird hitbox against NUM_PIPES pipes at once, plus the floor and ceiling, once per video frame.
- Keeps the running score and the high score, and drives the one-hot Initial/Check/Lose game state consumed by the renderer and the input controller.

Parameters:
- NUM_PIPES, 4: number of pipe channels evaluated in parallel (1..8).
- COORD_W, 10: width of all screen coordinates.
- BIRD_W, 16: bird hitbox width in pixels.
- BIRD_H, 12: bird hitbox height in pixels.
- SCORE_W, 8: score and high-score counter width.
- FLOOR_Y, 464: bird bottom edge (Bird_Y+BIRD_H) strictly greater than this is a hit.
- CEIL_Y, 0: Bird_Y strictly less than this is a hit.

Ports:
- Clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; begin game.
- Ack  in  1  level; acknowledge loss.
- Frame_Tick  in  1  one-cycle pulse per frame; the only evaluation instant.
- Bird_X  in  COORD_W  signed bird left edge.
- Bird_Y  in  COORD_W  signed bird top edge.
- Pipe_Valid  in  NUM_PIPES  per-pipe enable.
- Pipe_X_Left  in  NUM_PIPES*COORD_W  unsigned; pipe i at bits [i*COORD_W +: COORD_W].
- Pipe_X_Right  in  NUM_PIPES*COORD_W  unsigned; same packing.
- Gap_Top  in  NUM_PIPES*COORD_W  unsigned; top of the open gap.
- Gap_Bottom  in  NUM_PIPES*COORD_W  unsigned; bottom of the open gap.
- Q_Initial  out  1  state flag.
- Q_Check  out  1  state flag.
- Q_Lose  out  1  state flag.
- Score  out  SCORE_W  current score.
- High_Score  out  SCORE_W  best score since reset.
- Hit_Index  out  4  source of the loss: pipe index, or 4'd15 for floor/ceiling; valid in Lose.
- Pass_Pulse  out  1  one-cycle pulse on any score increment.

Behaviour:
- Reset values:
  - state = Initial, so {Q_Lose,Q_Check,Q_Initial} = 3'b001.
  - Score = 0, High_Score = 0, Hit_Index = 0, Pass_Pulse = 0.
  - All passed flags = 0.
  - Reset asserted mid-game aborts immediately to these values.
- State encoding: one-hot registered state, so exactly one Q_* flag is high. An illegal encoding recovers to Initial on the next clock.
- State transitions:
  - Initial -> Check when Start = 1. On that edge Score and all passed flags clear. Ack is ignored in Initial.
  - Check -> Lose on a Frame_Tick cycle with hit = 1, visible the following cycle (1-cycle latency). With no Frame_Tick, no evaluation occurs and the state holds.
  - Lose -> Initial when Ack = 1. Start is ignored in Lose. Score holds in Lose until the next game starts.
- Comparisons: all are signed at COORD_W+2 bits. Pipe inputs are zero-extended; bird inputs are sign-extended. Bird edges are bx0 = Bird_X, bx1 = Bird_X+BIRD_W, by0 = Bird_Y, by1 = Bird_Y+BIRD_H.
- Per-pipe hit(i) = Pipe_Valid[i] && (bx1 > Left_i) && (bx0 < Right_i) && (by0 < Gap_Top_i || by1 > Gap_Bottom_i). Edge contact (bx1 == Left_i, by0 == Gap_Top_i) is not a hit.
- Boundary hit = (by1 > FLOOR_Y) || (by0 < CEIL_Y).
- hit = OR of all hit(i) and the boundary hit.
- Hit_Index, latched on entry to Lose: the lowest i with hit(i); if no pipe hit, 15.
- Scoring, evaluated in Check on Frame_Tick only:
  - pass(i) = Pipe_Valid[i] && !passed[i] && (bx0 >= Right_i).
  - For each pass(i), set passed[i].
  - Score += popcount(pass). The sum saturates at 2^SCORE_W-1 and never wraps.
  - Pass_Pulse = 1 for the next cycle if popcount > 0.
- Passed-flag clear: passed[i] clears on any cycle where Pipe_Valid[i] = 0 or Left_i > bx1, i.e. the pipe has respawned ahead of the bird. Clear takes priority over set.
- Collision and pass on the same Frame_Tick: collision wins. Go to Lose with no score increment, no passed-flag update and no Pass_Pulse.
- High score: on the Check->Lose edge, High_Score <= max(High_Score, Score). It is not updated on reset-abort.

Test Plan:
- Reset then idle: after reset release, outputs are 001, Score = 0, High_Score = 0. Hold Ack = 1 for 5 cycles -> still 001.
- Gap pass:
  - Setup: Start; pipe0 Left = 100, Right = 140, Gap 200..300; Bird_Y = 240.
  - Step Bird_X 60, 90, 140 on successive Frame_Ticks.
  - Required: no Lose; Score 0 -> 1 after the X = 140 tick; one Pass_Pulse.
  - Repeat the tick at X = 150 -> Score stays 1.
- Pipe hit:
  - Same pipe with Bird_Y = 190 and Bird_X = 90 on Frame_Tick -> Q_Lose = 1 the next cycle, Hit_Index = 0, High_Score = prior Score.
  - Ack -> 001.
- Floor and edge contact:
  - Bird_Y = 453 (by1 = 465) -> Lose, Hit_Index = 15.
  - Separate run with Bird_X = 84 (bx1 = 100 == Left) and Bird_Y = 190 -> no hit.
- Multi-pass and saturation:
  - Force SCORE_W = 2, Score = 2, two pipes passed on one tick -> Score = 3 (saturated).
  - Pipe respawn (Left = 600) clears passed flags; a later pass stays at 3.
- Simultaneous events and reset abort:
  - Pipe0 passed and pipe1 hit on the same tick -> Lose, Score unchanged, Hit_Index = 1.
  - Assert reset mid-Check -> all outputs at reset values asynchronously, High_Score = 0.
